cache_arbiter: RTL

Arbitrates the single physical-memory (L2/pmem) line port between the instruction cache (read-only) and the data cache (read/write) in the pipelined RV32I core. Grants one requester at a time with round-robin priority on conflict. Forwards the memory response and read line back to the granted cache. Optionally exposes performance counters for `getperf` software readout.

---
 rtl/cache_arbiter_pkg.sv | 20 ++
 rtl/perf_counter.sv | 28 ++
 rtl/cache_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/cache_arbiter_pkg.sv
// Shared types for the cache/memory arbitration path of the RV32I core.
package rv32i_types;

   // Default cache line width in bits
   localparam int LINE_W = 256;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } arb_state_t;

   // Side that won the most recent grant
   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } arb_grant_t;

endpackage

// File: rtl/perf_counter.sv
// perf_counter: 32-bit wrapping event counter with synchronous clear.
// Clear has priority over increment in the same cycle.
module perf_counter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inc,
   input  logic        clr,
   output logic [31:0] count
);

   logic [31:0] count_r;

   // Count events; clear wins over increment; wraps naturally at 2^32
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= 32'd0;
      end else if (clr) begin
         count_r <= 32'd0;
      end else if (inc) begin
         count_r <= count_r + 32'd1;
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;

endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares the single memory line port between the I-cache
// (read only) and the D-cache (read/write). Round-robin on conflict, the
// first tie after reset goes to D. Memory strobes, address and write line
// are registered at grant time; responses are forwarded combinationally.
// Optional macro ARB_PERF_EN enables the grant/conflict perf counters;
// without it the counter outputs are constant zero and perf_clr is unused.
module cache_arbiter #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = rv32i_types::LINE_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              m_read,
   output logic              m_write,
   output logic [ADDR_W-1:0] m_addr,
   output logic [LINE_W-1:0] m_wdata,
   input  logic [LINE_W-1:0] m_rdata,
   input  logic              m_resp,
   input  logic              perf_clr,
   output logic [31:0]       perf_i_grants,
   output logic [31:0]       perf_d_grants,
   output logic [31:0]       perf_conflict
);

   import rv32i_types::*;

   arb_state_t        state_r, state_nxt_s;
   arb_grant_t        last_grant_r, last_grant_nxt_s;
   logic              i_req_s, d_req_s;
   logic              grant_i_s, grant_d_s;
   logic              m_read_r, m_write_r;
   logic [ADDR_W-1:0] m_addr_r;
   logic [LINE_W-1:0] m_wdata_r;

   assign i_req_s = i_read;
   assign d_req_s = d_read | d_write;

   // Grant decision and next-state logic
   always_comb begin
      state_nxt_s      = state_r;
      last_grant_nxt_s = last_grant_r;
      grant_i_s        = 1'b0;
      grant_d_s        = 1'b0;
      case (state_r)
         IDLE: begin
            if (i_req_s && d_req_s) begin
               if (last_grant_r == GRANT_I) begin
                  grant_d_s = 1'b1;
               end else begin
                  grant_i_s = 1'b1;
               end
            end else if (i_req_s) begin
               grant_i_s = 1'b1;
            end else if (d_req_s) begin
               grant_d_s = 1'b1;
            end else begin
               grant_i_s = 1'b0;
            end
            if (grant_d_s) begin
               state_nxt_s      = SERVE_D;
               last_grant_nxt_s = GRANT_D;
            end else if (grant_i_s) begin
               state_nxt_s      = SERVE_I;
               last_grant_nxt_s = GRANT_I;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         SERVE_I, SERVE_D: begin
            if (m_resp) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = state_r;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State and round-robin pointer registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         last_grant_r <= GRANT_I;
      end else begin
         state_r      <= state_nxt_s;
         last_grant_r <= last_grant_nxt_s;
      end
   end

   // Capture the winner's request at grant time; drop strobes on completion.
   // A simultaneous d_read/d_write is treated as a write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_read_r  <= 1'b0;
         m_write_r <= 1'b0;
         m_addr_r  <= '0;
         m_wdata_r <= '0;
      end else if (grant_d_s) begin
         m_read_r  <= ~d_write;
         m_write_r <= d_write;
         m_addr_r  <= d_addr;
         m_wdata_r <= d_wdata;
      end else if (grant_i_s) begin
         m_read_r  <= 1'b1;
         m_write_r <= 1'b0;
         m_addr_r  <= i_addr;
         m_wdata_r <= '0;
      end else if (m_resp) begin
         m_read_r  <= 1'b0;
         m_write_r <= 1'b0;
      end else begin
         m_read_r  <= m_read_r;
         m_write_r <= m_write_r;
      end
   end

   assign m_read  = m_read_r;
   assign m_write = m_write_r;
   assign m_addr  = m_addr_r;
   assign m_wdata = m_wdata_r;

   // Completion pulses only for the side being served; idle m_resp is dropped
   assign i_resp  = (state_r == SERVE_I) & m_resp;
   assign d_resp  = (state_r == SERVE_D) & m_resp;
   assign i_rdata = m_rdata;
   assign d_rdata = m_rdata;

`ifdef ARB_PERF_EN
   logic conflict_s;

   // A cycle counts as conflicted when a request waits behind the other side
   always_comb begin
      conflict_s = 1'b0;
      case (state_r)
         IDLE:    conflict_s = i_req_s & d_req_s;
         SERVE_I: conflict_s = d_req_s;
         SERVE_D: conflict_s = i_req_s;
         default: conflict_s = 1'b0;
      endcase
   end

   perf_counter u_perf_i (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (grant_i_s),
      .clr   (perf_clr),
      .count (perf_i_grants)
   );

   perf_counter u_perf_d (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (grant_d_s),
      .clr   (perf_clr),
      .count (perf_d_grants)
   );

   perf_counter u_perf_c (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (conflict_s),
      .clr   (perf_clr),
      .count (perf_conflict)
   );
`else
   logic unused_perf_clr_s;
   assign unused_perf_clr_s = perf_clr;
   assign perf_i_grants     = 32'd0;
   assign perf_d_grants     = 32'd0;
   assign perf_conflict     = 32'd0;
`endif

endmodule
